// File: rtl/dma_mem_to_tx.sv
// Memory-to-UART-TX DMA read engine: reads a programmed block from memory_module and streams it bytewise.
// Optional running byte checksum output enabled by defining DMA_TX_CHECKSUM_EN.
module dma_mem_to_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_read_address,
    output logic                  mem_re,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready
`ifdef DMA_TX_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_SEND,
        S_DONE
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH:0]   remaining;
    logic                  start_ok;
    logic                  accept;

    assign start_ok = (state_q == S_IDLE) && start;
    // tx_valid is high exactly while in SEND, so the state decode stands in for it.
    assign accept   = (state_q == S_SEND) && tx_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = (length == '0) ? S_DONE : S_READ;
            S_READ: state_d = S_WAIT;
            S_WAIT: state_d = S_SEND;
            S_SEND: if (tx_ready) state_d = (remaining == 1) ? S_DONE : S_READ;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cur_addr  <= '0;
            remaining <= '0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
        end else begin
            if (start_ok && (length != '0)) begin
                cur_addr  <= src_addr;
                remaining <= length;
            end
            // Memory data is registered on the READ edge, so it is valid during WAIT.
            if (state_q == S_WAIT) begin
                tx_data  <= mem_data_out;
                tx_valid <= 1'b1;
            end
            if (accept) begin
                tx_valid  <= 1'b0;
                cur_addr  <= cur_addr + 1'b1;
                remaining <= remaining - 1'b1;
            end
        end
    end

`ifdef DMA_TX_CHECKSUM_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)         checksum <= '0;
        else if (start_ok) checksum <= '0;
        else if (accept)   checksum <= checksum + tx_data;
    end
`endif

    assign busy             = (state_q != S_IDLE);
    assign done             = (state_q == S_DONE);
    assign mem_re           = (state_q == S_READ);
    assign mem_read_address = cur_addr;

endmodule

// File: tb/tb_dma_mem_to_tx.sv
// Scoreboard bench for dma_mem_to_tx: stimulus pushes expected reads/bytes, a negedge monitor pops and compares.
module tb_dma_mem_to_tx;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic [7:0] src_addr = '0;
    logic [8:0] length = '0;
    logic       busy, done, mem_re, tx_valid;
    logic [7:0] mem_read_address, tx_data;
    logic [7:0] mem_data_out = '0;
    logic       tx_ready = 1'b1;
`ifdef DMA_TX_CHECKSUM_EN
    logic [7:0] checksum;
`endif

    dma_mem_to_tx #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rstn(rstn), .start(start), .src_addr(src_addr), .length(length),
        .busy(busy), .done(done), .mem_read_address(mem_read_address), .mem_re(mem_re),
        .mem_data_out(mem_data_out), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
`ifdef DMA_TX_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural memory_module read port: data registered on edges with re=1.
    logic [7:0] mem [256];
    always @(posedge clk) if (mem_re) mem_data_out <= mem[mem_read_address];

    int n_checks = 0;
    int n_pass = 0;
    logic [7:0] exp_bytes[$];
    logic [7:0] exp_addrs[$];
    int n_accepted = 0;
    int stall_idx = -1;
    int stall_left = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // tx_ready driver: low for stall_left cycles while the byte with index stall_idx is offered.
    always @(posedge clk) begin
        #1;
        if (tx_valid && n_accepted == stall_idx && stall_left > 0) begin
            tx_ready = 1'b0;
            stall_left--;
        end else begin
            tx_ready = 1'b1;
        end
    end

    // Monitor: read addresses, accepted bytes, and stability of a stalled byte.
    logic       stalled = 1'b0;
    logic [7:0] held = '0;
    always @(negedge clk) begin
        if (!rstn) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("hold_valid", tx_valid, 1);
                check("hold_data", tx_data, held);
            end
            if (mem_re) begin
                if (exp_addrs.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_mem_re: got read at 0x%0h, required none", mem_read_address);
                end else check("read_addr", mem_read_address, exp_addrs.pop_front());
            end
            if (tx_valid && tx_ready) begin
                if (exp_bytes.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_tx_byte: got 0x%0h, required none", tx_data);
                end else check("tx_byte", tx_data, exp_bytes.pop_front());
                n_accepted++;
            end
            stalled = tx_valid && !tx_ready;
            held    = tx_data;
        end
    end

    task automatic push_expect(input logic [7:0] a, input logic [8:0] len, output logic [7:0] sum);
        logic [7:0] ad;
        sum = '0;
        for (int i = 0; i < int'(len); i++) begin
            ad = a + 8'(i);
            exp_addrs.push_back(ad);
            exp_bytes.push_back(mem[ad]);
            sum = sum + mem[ad];
        end
    endtask

    task automatic pulse_start(input logic [7:0] a, input logic [8:0] len);
        @(negedge clk);
        src_addr = a;
        length   = len;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic run_xfer(input logic [7:0] a, input logic [8:0] len, input int exp_cycles);
        int cycles;
        logic [7:0] sum;
        push_expect(a, len, sum);
        pulse_start(a, len);
        cycles = 1;
        while (!done && cycles < 1000) begin
            @(negedge clk);
            cycles++;
        end
        check("cycles_to_done", cycles, exp_cycles);
        check("busy_during_done", busy, 1);
`ifdef DMA_TX_CHECKSUM_EN
        check("checksum", checksum, sum);
`endif
        @(negedge clk);
        check("done_single_cycle", done, 0);
        check("busy_after_done", busy, 0);
        check("bytes_drained", exp_bytes.size(), 0);
        check("reads_drained", exp_addrs.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        int base;
        int guard;
        logic [7:0] dummy;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h5A);
        for (int i = 0; i < 5; i++) mem[i] = 8'hA0 + 8'(i);

        // Reset held with start and tx_ready high.
        start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_mem_re", mem_re, 0);
            check("rst_tx_valid", tx_valid, 0);
        end
        start = 1'b0;
        @(negedge clk) rstn = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("post_rst_busy", busy, 0);
            check("post_rst_tx_valid", tx_valid, 0);
        end

        // Basic: 5 bytes, 3 cycles each, done one cycle later.
        run_xfer(8'h00, 9'd5, 16);

        // Backpressure: 4 stalled cycles on the 2nd byte.
        stall_idx  = n_accepted + 1;
        stall_left = 4;
        run_xfer(8'h00, 9'd5, 20);
        check("stall_consumed", stall_left, 0);
        stall_idx = -1;

        // Address wrap through 0xFF -> 0x00.
        mem[8'hFE] = 8'h11;
        mem[8'hFF] = 8'hBB;
        mem[8'h00] = 8'hCC;
        run_xfer(8'hFE, 9'd3, 10);
        mem[8'h00] = 8'hA0;

        // Zero length: immediate done, no reads, no bytes.
        run_xfer(8'h00, 9'd0, 1);

        // Start pulsed mid-transfer is ignored.
        fork
            run_xfer(8'h00, 9'd5, 16);
            begin
                repeat (6) @(negedge clk);
                src_addr = 8'h40;
                length   = 9'd2;
                start    = 1'b1;
                @(negedge clk);
                start    = 1'b0;
            end
        join

        // Reset after the 2nd byte of a 5-byte transfer.
        push_expect(8'h00, 9'd5, dummy);
        base = n_accepted;
        pulse_start(8'h00, 9'd5);
        guard = 0;
        while (n_accepted < base + 2 && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        check("mid_rst_reached_2nd_byte", n_accepted - base, 2);
        #3 rstn = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_mem_re", mem_re, 0);
        check("mid_rst_tx_valid", tx_valid, 0);
        check("mid_rst_tx_data", tx_data, 0);
        check("mid_rst_addr", mem_read_address, 0);
        exp_bytes.delete();
        exp_addrs.delete();
        repeat (2) begin
            @(negedge clk);
            check("mid_rst_no_done", done, 0);
        end
        rstn = 1'b1;
        @(negedge clk);
        check("post_mid_rst_idle", busy, 0);
        run_xfer(8'h00, 9'd1, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
